// File: rtl/mem_data_lsu.sv
// Load/store initiator for the data port of the simulation memory model: one access at a time,
// a single-cycle read or write strobe, and a formatted response. Optional: LSU_MISALIGN_CHECK_EN.
module mem_data_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pReq_bValid,
  output logic                  pReq_bReady,
  input  logic                  pReq_bWr,
  input  logic [1:0]            pReq_bSize,
  input  logic                  pReq_bSigned,
  input  logic [ADDR_WIDTH-1:0] pReq_bAddr,
  input  logic [DATA_WIDTH-1:0] pReq_bData,
  output logic                  pResp_bValid,
  input  logic                  pResp_bReady,
  output logic [DATA_WIDTH-1:0] pResp_bData,
  output logic                  pResp_bErr,
  output logic                  pMemData_pRd_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
  input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
  output logic                  pMemData_pWr_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
  output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
  output logic                  pMemData_pWr_bMask_0,
  output logic                  pMemData_pWr_bMask_1,
  output logic                  pMemData_pWr_bMask_2,
  output logic                  pMemData_pWr_bMask_3
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    wr_q, sgn_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q, resp_data_q;
  logic                    req_fire, misalign;
  logic [3:0]              mask;

  assign req_fire = pReq_bValid & pReq_bReady;

`ifdef LSU_MISALIGN_CHECK_EN
  logic resp_err_q;
  assign misalign = ((pReq_bSize == 2'd1) && pReq_bAddr[0]) ||
                    (pReq_bSize[1] && (pReq_bAddr[1:0] != 2'b00));
  assign pResp_bErr = (state == RESP) & resp_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         resp_err_q <= 1'b0;
    else if (req_fire) resp_err_q <= misalign;
  end
`else
  assign misalign   = 1'b0;
  assign pResp_bErr = 1'b0;
`endif

  // Load formatting always takes the low bits of the returned word; the model does byte addressing.
  function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [1:0] sz, input logic sg,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (sz)
      2'd0:    load_fmt = {{(DATA_WIDTH-8){sg & d[7]}}, d[7:0]};
      2'd1:    load_fmt = {{(DATA_WIDTH-16){sg & d[15]}}, d[15:0]};
      default: load_fmt = d;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = misalign ? RESP : (pReq_bWr ? WRITE : READ);
      READ:    state_nxt = RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (pResp_bReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else if (req_fire) begin
      wr_q        <= pReq_bWr;
      sgn_q       <= pReq_bSigned;
      size_q      <= pReq_bSize;
      addr_q      <= pReq_bAddr;
      data_q      <= pReq_bData;
      resp_data_q <= '0;
    end else if (state == READ) begin
      resp_data_q <= load_fmt(size_q, sgn_q, pMemData_pRd_bData);
    end
  end

  // Mask bit order is {_0,_1,_2,_3}; zeros outside WRITE so repeated identical stores re-trigger.
  always_comb begin
    mask = 4'b0000;
    if (state == WRITE) begin
      case (size_q)
        2'd0:    mask = 4'b0001;
        2'd1:    mask = 4'b0011;
        default: mask = 4'b1111;
      endcase
    end
  end

  assign {pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
          pMemData_pWr_bMask_2, pMemData_pWr_bMask_3} = mask;

  assign pReq_bReady        = (state == IDLE) & ~reset;
  assign pMemData_pRd_bEn   = (state == READ);
  assign pMemData_pRd_bAddr = (state == READ) ? addr_q : '0;
  assign pMemData_pWr_bEn   = (state == WRITE) & wr_q;
  assign pMemData_pWr_bAddr = (state == WRITE) ? addr_q : '0;
  assign pMemData_pWr_bData = (state == WRITE) ? data_q : '0;
  assign pResp_bValid       = (state == RESP);
  assign pResp_bData        = (state == RESP) ? resp_data_q : '0;

endmodule

// File: tb/tb_mem_data_lsu.sv
// Randomized bench for mem_data_lsu with a behavioural model of load formatting, masks and timing.
module tb_mem_data_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0, req_sgn = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_data;
  logic        rd_en, wr_en, m0, m1, m2, m3;
  logic [31:0] rd_addr, rd_data = '0, wr_addr, wr_data;

  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;

  mem_data_lsu dut (
    .clock(clock), .reset(reset),
    .pReq_bValid(req_valid), .pReq_bReady(req_ready), .pReq_bWr(req_wr),
    .pReq_bSize(req_size), .pReq_bSigned(req_sgn), .pReq_bAddr(req_addr),
    .pReq_bData(req_data),
    .pResp_bValid(resp_valid), .pResp_bReady(resp_ready), .pResp_bData(resp_data),
    .pResp_bErr(resp_err),
    .pMemData_pRd_bEn(rd_en), .pMemData_pRd_bAddr(rd_addr), .pMemData_pRd_bData(rd_data),
    .pMemData_pWr_bEn(wr_en), .pMemData_pWr_bAddr(wr_addr), .pMemData_pWr_bData(wr_data),
    .pMemData_pWr_bMask_0(m0), .pMemData_pWr_bMask_1(m1),
    .pMemData_pWr_bMask_2(m2), .pMemData_pWr_bMask_3(m3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d % 256;
      if (sg && v >= 128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = d % 65536;
      if (sg && v >= 32768) v = v - 32'd65536;
    end else v = d;
    return v;
  endfunction

  function automatic logic [31:0] exp_mask(input logic [1:0] sz);
    if (sz == 2'd0)      return 32'b0001;
    else if (sz == 2'd1) return 32'b0011;
    else                 return 32'b1111;
  endfunction

  function automatic bit exp_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] mem,
                        input int hold);
    logic [31:0] exp_d;
    bit          mis;
    mis   = exp_misalign(sz, a);
    exp_d = (wr || mis) ? 32'd0 : exp_load(sz, sg, mem);
    @(negedge clock);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_sgn = sg; req_addr = a; req_data = d;
    rd_data = mem;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (mis) begin
      chk("mis_rd_en", {31'd0, rd_en}, 32'd0);
      chk("mis_wr_en", {31'd0, wr_en}, 32'd0);
    end else begin
      chk("c1_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("c1_rd_en", {31'd0, rd_en}, {31'd0, ~wr});
      chk("c1_wr_en", {31'd0, wr_en}, {31'd0, wr});
      chk("c1_mask", {28'd0, m0, m1, m2, m3}, wr ? exp_mask(sz) : 32'd0);
      if (wr) begin
        chk("c1_wr_addr", wr_addr, a);
        chk("c1_wr_data", wr_data, d);
        chk("c1_rd_addr", rd_addr, 32'd0);
      end else begin
        chk("c1_rd_addr", rd_addr, a);
        chk("c1_wr_addr", wr_addr, 32'd0);
      end
      @(negedge clock);
      rd_data = $urandom;
    end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clock);
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_data", resp_data, exp_d);
      chk("resp_err", {31'd0, resp_err}, {31'd0, mis});
      chk("resp_mem_en", {30'd0, rd_en, wr_en}, 32'd0);
      chk("resp_mask", {28'd0, m0, m1, m2, m3}, 32'd0);
      chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
      // A request offered during RESP must not be taken.
      if (hold > 0) req_valid = 1'b1;
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0; req_valid = 1'b0;
    chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_mem_en", {30'd0, rd_en, wr_en}, 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_en", {30'd0, rd_en, wr_en}, 32'd0);
    chk("rst_mask", {28'd0, m0, m1, m2, m3}, 32'd0);
    chk("rst_addr", rd_addr | wr_addr | wr_data, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1 chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    access(1'b1, 2'd2, 1'b0, 32'h80000100, 32'hDEADBEEF, 32'h0, 0);
    access(1'b1, 2'd2, 1'b0, 32'h80000100, 32'hDEADBEEF, 32'h0, 0);
    access(1'b0, 2'd0, 1'b1, 32'h80000101, 32'h0, 32'h000000F3, 0);
    access(1'b0, 2'd0, 1'b0, 32'h80000101, 32'h0, 32'h000000F3, 0);
    access(1'b0, 2'd1, 1'b1, 32'h80000200, 32'h0, 32'h12348001, 0);
    access(1'b1, 2'd1, 1'b0, 32'h80000200, 32'h00005555, 32'h0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h80000300, 32'h0, 32'hCAFEF00D, 5);
    access(1'b0, 2'd2, 1'b0, 32'h80000002, 32'h0, 32'h89ABCDEF, 0);
    access(1'b0, 2'd3, 1'b1, 32'h80000001, 32'h0, 32'h89ABCDEF, 1);
    access(1'b1, 2'd1, 1'b0, 32'h80000003, 32'h0000AAAA, 32'h0, 0);

    // Reset in the middle of a WRITE cycle.
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h80000400; req_data = 32'h1234;
    @(posedge clock);
    #1 req_valid = 1'b0;
    #1 chk("mid_wr_en_before", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    #1 chk("mid_wr_en_drop", {31'd0, wr_en}, 32'd0);
    chk("mid_wr_addr", wr_addr, 32'd0);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("mid_no_mem", {30'd0, rd_en, wr_en}, 32'd0);

    for (int n = 0; n < 120; n++)
      access($urandom_range(1, 0), 2'($urandom_range(3, 0)), $urandom_range(1, 0),
             $urandom, $urandom, $urandom, $urandom_range(3, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
